// File: rtl/ex_operand_stage.sv
// Execute-stage operand register: single-entry valid/ready pipeline slot between decode
// and the ALU, with rs1/rs2 forwarding from MEM/WB and forwarding refresh while stalled.
module ex_operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic [4:0]  in_shamt,
  input  logic [3:0]  in_cntr,
  input  logic        in_not_s,
  input  logic        in_wb_en,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] srca,
  output logic [31:0] srcb,
  output logic [4:0]  shamt,
  output logic [3:0]  cntr,
  output logic        not_s,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        illegal_op,
  input  logic        mem_wb_en,
  input  logic        wb_wb_en,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] mem_result,
  input  logic [31:0] wb_result
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 4;

  localparam logic [OPW-1:0] OP_ADD = 4'b0000;
  localparam logic [OPW-1:0] OP_AM  = 4'b1000;

  logic            valid_q;
  logic [RW-1:0]   rs1_q, rs2_q, rd_q, shamt_q;
  logic [XLEN-1:0] rs1_val_q, rs2_val_q, imm_q;
  logic            use_imm_q, not_s_q, wb_en_q, illegal_q;
  logic [OPW-1:0]  cntr_q;

  logic            capture;
  logic            stall;
  logic            op_legal;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready;
  assign stall    = valid_q && !out_ready;
  assign op_legal = (in_cntr <= OP_AM);

  // Operand bypass: MEM is younger than WB, so it wins; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_val_q;
    fwd_rs2 = rs2_val_q;
    if (mem_wb_en && (mem_rd == rs1_q) && (rs1_q != '0)) begin
      fwd_rs1 = mem_result;
    end else if (wb_wb_en && (wb_rd == rs1_q) && (rs1_q != '0)) begin
      fwd_rs1 = wb_result;
    end
    if (mem_wb_en && (mem_rd == rs2_q) && (rs2_q != '0)) begin
      fwd_rs2 = mem_result;
    end else if (wb_wb_en && (wb_rd == rs2_q) && (rs2_q != '0)) begin
      fwd_rs2 = wb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      not_s_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      cntr_q    <= OP_ADD;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q   <= 1'b1;
      rs1_q     <= in_rs1;
      rs2_q     <= in_rs2;
      rd_q      <= in_rd;
      shamt_q   <= in_shamt;
      rs1_val_q <= in_rs1_val;
      rs2_val_q <= in_rs2_val;
      imm_q     <= in_imm;
      use_imm_q <= in_use_imm;
      not_s_q   <= in_not_s;
      // Illegal ops become a harmless ADD that never writes back.
      wb_en_q   <= in_wb_en && op_legal;
      illegal_q <= !op_legal;
      cntr_q    <= op_legal ? in_cntr : OP_ADD;
    end else if (stall) begin
      // Absorb forwarded results so producers retiring during the stall are not lost.
      rs1_val_q <= fwd_rs1;
      rs2_val_q <= fwd_rs2;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid  = valid_q;
  assign srca       = fwd_rs1;
  assign srcb       = use_imm_q ? imm_q : fwd_rs2;
  assign shamt      = use_imm_q ? shamt_q : fwd_rs2[RW-1:0];
  assign cntr       = cntr_q;
  assign not_s      = not_s_q;
  assign out_rd     = rd_q;
  assign out_wb_en  = wb_en_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed vector table followed by random traffic
// checked against a transaction-level reference model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd, in_shamt;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic        in_use_imm, in_not_s, in_wb_en, flush, out_ready, out_valid;
  logic [3:0]  in_cntr, cntr;
  logic [31:0] srca, srcb;
  logic [4:0]  shamt, out_rd;
  logic        not_s, out_wb_en, illegal_op;
  logic        mem_wb_en, wb_wb_en;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_shamt(in_shamt), .in_cntr(in_cntr),
    .in_not_s(in_not_s), .in_wb_en(in_wb_en), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .srca(srca), .srcb(srcb),
    .shamt(shamt), .cntr(cntr), .not_s(not_s), .out_rd(out_rd),
    .out_wb_en(out_wb_en), .illegal_op(illegal_op),
    .mem_wb_en(mem_wb_en), .wb_wb_en(wb_wb_en), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_result(mem_result), .wb_result(wb_result)
  );

  typedef struct packed {
    logic        r, iv;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    logic        ui;
    logic [4:0]  sh;
    logic [3:0]  op;
    logic        ns, we, fl, ordy, mwe;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic        chk, cf, ev, er;
    logic [31:0] ea, eb;
    logic [4:0]  es;
    logic [3:0]  ec;
    logic        eill, ewe;
  } vec_t;

  vec_t tbl[$];
  vec_t v;
  int   n_err = 0;
  int   n_chk = 0;

  // Reference model state: the instruction currently held by the stage.
  logic        m_valid, m_ui, m_ns, m_we, m_ill, m_rdy;
  logic [4:0]  m_rs1, m_rs2, m_rd, m_sh;
  logic [31:0] m_v1, m_v2, m_imm, e_a, e_b;
  logic [3:0]  m_op;

  function automatic vec_t idle();
    vec_t t;
    t = '0;
    t.ordy = 1'b1;
    return t;
  endfunction

  function automatic vec_t cap(vec_t t, logic [4:0] rs1, logic [31:0] v1,
                               logic [4:0] rs2, logic [31:0] v2, logic [3:0] op, logic we);
    t.iv = 1'b1; t.rs1 = rs1; t.v1 = v1; t.rs2 = rs2; t.v2 = v2; t.op = op; t.we = we;
    return t;
  endfunction

  function automatic vec_t ex(vec_t t, logic ev, logic er, logic [31:0] ea, logic [31:0] eb,
                              logic [4:0] es, logic [3:0] ec, logic eill, logic ewe);
    t.chk = 1'b1; t.cf = ev; t.ev = ev; t.er = er; t.ea = ea; t.eb = eb;
    t.es = es; t.ec = ec; t.eill = eill; t.ewe = ewe;
    return t;
  endfunction

  function automatic logic [31:0] mfwd(logic [4:0] idx, logic [31:0] held, vec_t t);
    if (idx != 5'd0 && t.mwe && t.mrd == idx) return t.mres;
    if (idx != 5'd0 && t.wwe && t.wrd == idx) return t.wres;
    return held;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(vec_t t);
    @(negedge clk);
    rst = t.r; in_valid = t.iv; in_rs1 = t.rs1; in_rs2 = t.rs2; in_rd = t.rd;
    in_rs1_val = t.v1; in_rs2_val = t.v2; in_imm = t.imm; in_use_imm = t.ui;
    in_shamt = t.sh; in_cntr = t.op; in_not_s = t.ns; in_wb_en = t.we;
    flush = t.fl; out_ready = t.ordy; mem_wb_en = t.mwe; mem_rd = t.mrd;
    mem_result = t.mres; wb_wb_en = t.wwe; wb_rd = t.wrd; wb_result = t.wres;
  endtask

  initial begin
    // Directed rows: inputs for one cycle, expected outputs before that cycle's edge.
    v = idle(); v.r = 1'b1; tbl.push_back(v);
    v = ex(idle(), 0, 1, 0, 0, 0, 0, 0, 0); v.cf = 1'b1; tbl.push_back(v);
    v = cap(idle(), 1, 5, 2, 5, 4'h0, 1); v.rd = 7; tbl.push_back(ex(v, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idle(), 1, 1, 5, 5, 5, 0, 0, 1));
    tbl.push_back(ex(idle(), 0, 1, 5, 5, 5, 0, 0, 1));
    v = cap(idle(), 3, 1, 0, 32'h44, 4'h2, 1); v.ordy = 0; tbl.push_back(ex(v, 0, 1, 0, 0, 0, 0, 0, 0));
    v = idle(); v.ordy = 0; v.mwe = 1; v.mrd = 3; v.mres = 32'h10; v.wwe = 1; v.wrd = 3; v.wres = 32'h20;
    tbl.push_back(ex(v, 1, 0, 32'h10, 32'h44, 4, 4'h2, 0, 1));
    tbl.push_back(ex(idle(), 1, 1, 32'h10, 32'h44, 4, 4'h2, 0, 1));
    v = cap(idle(), 0, 32'h55, 2, 32'h23, 4'h5, 1); tbl.push_back(ex(v, 0, 1, 0, 0, 0, 0, 0, 0));
    v = idle(); v.mwe = 1; v.mrd = 0; v.mres = 32'h10; v.wwe = 1; v.wrd = 0; v.wres = 32'h20;
    tbl.push_back(ex(v, 1, 1, 32'h55, 32'h23, 3, 4'h5, 0, 1));
    v = cap(idle(), 1, 1, 4, 7, 4'h1, 1); tbl.push_back(ex(v, 0, 1, 0, 0, 0, 0, 0, 0));
    v = idle(); v.ordy = 0; v.wwe = 1; v.wrd = 4; v.wres = 9;
    tbl.push_back(ex(v, 1, 0, 1, 9, 9, 4'h1, 0, 1));
    v = idle(); v.ordy = 0; tbl.push_back(ex(v, 1, 0, 1, 9, 9, 4'h1, 0, 1));
    tbl.push_back(ex(idle(), 1, 1, 1, 9, 9, 4'h1, 0, 1));
    v = cap(idle(), 1, 32'h8000_0000, 2, 32'h23, 4'h7, 1); v.ui = 1; v.imm = 32'hFFFF_FFFB; v.sh = 2;
    tbl.push_back(ex(v, 0, 1, 0, 0, 0, 0, 0, 0));
    v = cap(idle(), 1, 32'h8000_0000, 2, 32'h23, 4'h7, 1); v.sh = 2;
    tbl.push_back(ex(v, 1, 1, 32'h8000_0000, 32'hFFFF_FFFB, 2, 4'h7, 0, 1));
    tbl.push_back(ex(idle(), 1, 1, 32'h8000_0000, 32'h23, 3, 4'h7, 0, 1));
    v = cap(idle(), 0, 0, 0, 0, 4'b1011, 1); v.rd = 5; tbl.push_back(ex(v, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idle(), 1, 1, 0, 0, 0, 4'h0, 1, 0));
    v = cap(idle(), 0, 32'hA, 0, 0, 4'h3, 1); v.fl = 1; tbl.push_back(ex(v, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idle(), 0, 1, 0, 0, 0, 0, 0, 0));
    v = cap(idle(), 0, 32'h1234, 0, 0, 4'h6, 1); v.ordy = 0; tbl.push_back(ex(v, 0, 1, 0, 0, 0, 0, 0, 0));
    v = idle(); v.ordy = 0; tbl.push_back(ex(v, 1, 0, 32'h1234, 0, 0, 4'h6, 0, 1));
    v = idle(); v.ordy = 0; v.r = 1; tbl.push_back(ex(v, 1, 0, 32'h1234, 0, 0, 4'h6, 0, 1));
    v = idle(); v.ordy = 0; v = ex(v, 0, 1, 0, 0, 0, 0, 0, 0); v.cf = 1'b1; tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      if (tbl[i].chk) begin
        check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
        check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].er));
        if (tbl[i].cf) begin
          check($sformatf("row%0d srca", i), srca, tbl[i].ea);
          check($sformatf("row%0d srcb", i), srcb, tbl[i].eb);
          check($sformatf("row%0d shamt", i), 32'(shamt), 32'(tbl[i].es));
          check($sformatf("row%0d cntr", i), 32'(cntr), 32'(tbl[i].ec));
          check($sformatf("row%0d illegal_op", i), 32'(illegal_op), 32'(tbl[i].eill));
          check($sformatf("row%0d out_wb_en", i), 32'(out_wb_en), 32'(tbl[i].ewe));
        end
      end
    end

    // Random traffic against the reference model, starting from a reset cycle.
    m_valid = 0; m_ui = 0; m_ns = 0; m_we = 0; m_ill = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_sh = 0; m_v1 = 0; m_v2 = 0; m_imm = 0; m_op = 0;
    v = idle(); v.r = 1'b1; drive(v);
    for (int n = 0; n < 600; n++) begin
      v = idle();
      v.r    = ($urandom_range(0, 99) == 0);
      v.iv   = 1'($urandom_range(0, 1));
      v.rs1  = 5'($urandom_range(0, 3));
      v.rs2  = 5'($urandom_range(0, 3));
      v.rd   = 5'($urandom_range(0, 31));
      v.v1   = $urandom;
      v.v2   = $urandom;
      v.imm  = $urandom;
      v.ui   = 1'($urandom_range(0, 1));
      v.sh   = 5'($urandom_range(0, 31));
      v.op   = 4'($urandom_range(0, 15));
      v.ns   = 1'($urandom_range(0, 1));
      v.we   = 1'($urandom_range(0, 1));
      v.fl   = ($urandom_range(0, 15) == 0);
      v.ordy = ($urandom_range(0, 3) != 0);
      v.mwe  = 1'($urandom_range(0, 1));
      v.mrd  = 5'($urandom_range(0, 3));
      v.mres = $urandom;
      v.wwe  = 1'($urandom_range(0, 1));
      v.wrd  = 5'($urandom_range(0, 3));
      v.wres = $urandom;
      drive(v);
      #1;
      m_rdy = !m_valid || v.ordy;
      e_a = mfwd(m_rs1, m_v1, v);
      e_b = mfwd(m_rs2, m_v2, v);
      check($sformatf("rnd%0d out_valid", n), 32'(out_valid), 32'(m_valid));
      check($sformatf("rnd%0d in_ready", n), 32'(in_ready), 32'(m_rdy));
      if (m_valid) begin
        check($sformatf("rnd%0d srca", n), srca, e_a);
        check($sformatf("rnd%0d srcb", n), srcb, m_ui ? m_imm : e_b);
        check($sformatf("rnd%0d shamt", n), 32'(shamt), 32'(m_ui ? m_sh : e_b[4:0]));
        check($sformatf("rnd%0d cntr", n), 32'(cntr), 32'(m_op));
        check($sformatf("rnd%0d not_s", n), 32'(not_s), 32'(m_ns));
        check($sformatf("rnd%0d out_rd", n), 32'(out_rd), 32'(m_rd));
        check($sformatf("rnd%0d out_wb_en", n), 32'(out_wb_en), 32'(m_we));
        check($sformatf("rnd%0d illegal_op", n), 32'(illegal_op), 32'(m_ill));
      end
      // Advance the model by the transaction this cycle's edge performs.
      if (v.r) begin
        m_valid = 0; m_ui = 0; m_ns = 0; m_we = 0; m_ill = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_sh = 0; m_v1 = 0; m_v2 = 0; m_imm = 0; m_op = 0;
      end else begin
        if (m_valid && !v.ordy) begin
          m_v1 = e_a;
          m_v2 = e_b;
        end
        if (v.fl) begin
          m_valid = 0;
        end else if (v.iv && m_rdy) begin
          m_valid = 1; m_rs1 = v.rs1; m_rs2 = v.rs2; m_rd = v.rd; m_v1 = v.v1; m_v2 = v.v2;
          m_imm = v.imm; m_ui = v.ui; m_sh = v.sh; m_ns = v.ns;
          m_ill = (v.op > 4'd8);
          m_op  = m_ill ? 4'd0 : v.op;
          m_we  = v.we && !m_ill;
        end else if (m_valid && v.ordy) begin
          m_valid = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- in_rs1_val, in_rs2_val  in  32 each  register-file read data
- in_imm  in  32  sign-extended immediate
- in_use_imm  in  1  srcb = immediate
- in_shamt  in  5  immediate shift amount
- in_cntr  in  4  ALU op code
- in_not_s  in  1  unsigned-compare select
- in_wb_en  in  1  writes rd
- flush  in  1  discard held instruction
- out_ready  in  1  ALU/EX consumer accepts
- out_valid  out  1  held instruction valid
- srca, srcb  out  32 each  ALU operands
- shamt  out  5  ALU shift amount
- cntr  out  4  ALU op code
- not_s  out  1  to ALU
- out_rd  out  5;  out_wb_en  out  1
- illegal_op  out  1  held op code was invalid
- mem_wb_en, wb_wb_en  in  1 each  forwarding-source write enables
- mem_rd, wb_rd  in  5 each  forwarding-source destinations
- mem_result, wb_result  in  32 each  forwarding data

Function
REQ-003 Op codes: ADD 0000, AND 0001, OR 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, AM 1000; 1001-1111 invalid.
REQ-004 SHALL be a single-entry pipeline register between decode and ALU, valid/ready handshake on both sides.
REQ-005 in_ready SHALL equal (!out_valid || out_ready) combinationally; flush does not affect in_ready.
REQ-006 Capture on in_valid && in_ready: all in_* fields latched, out_valid=1 next cycle.
REQ-007 Drain without capture (out_valid && out_ready && !(in_valid && in_ready)) SHALL set out_valid=0 next cycle.
REQ-008 Stall (out_valid && !out_ready) SHALL hold all fields and out_valid; in_ready=0.
REQ-009 flush SHALL clear out_valid next cycle and override a same-cycle capture (incoming instruction dropped).
REQ-010 Invalid in_cntr SHALL be latched as ADD (0000) with illegal_op=1 and out_wb_en=0; valid codes latch illegal_op=0.
REQ-011 Forwarding per operand (rs1, rs2), combinational on held index: mem source if mem_wb_en && mem_rd==idx && idx!=0; else wb source if wb_wb_en && wb_rd==idx && idx!=0; else held value. mem has priority over wb.
REQ-012 srca SHALL equal forwarded rs1; srcb SHALL equal held imm if use_imm, else forwarded rs2.
REQ-013 shamt SHALL equal held in_shamt if use_imm, else forwarded rs2[4:0].
REQ-014 During a stall, each held operand value SHALL be overwritten at the clock edge with its forwarded value, so forwarding sources that retire during the stall are not lost.
REQ-015 cntr, not_s, out_rd, out_wb_en, illegal_op SHALL be direct register outputs; srca/srcb/shamt combinational from registers plus forwarding inputs.
REQ-016 Outputs other than out_valid/in_ready are don't-care while out_valid=0 but SHALL still be driven deterministically from registers.

Reset
REQ-017 rst SHALL, at the clock edge, set out_valid=0, illegal_op=0, out_wb_en=0, cntr=0000, not_s=0, out_rd=0, and all held operand/imm/shamt/index registers to 0.
REQ-018 rst SHALL take priority over capture, flush and stall; an instruction held at reset is discarded.
REQ-019 After reset, srca=srcb=0 and shamt=0 absent forwarding; in_ready=1.

Verification
REQ-020 Capture ADD: rs1_val=5, rs2_val=5, use_imm=0, out_ready=1 -> next cycle out_valid=1, srca=5, srcb=5, cntr=0000; following idle cycle out_valid=0.
REQ-021 Forward priority: held rs1=3, mem_rd=3 mem_result=0x10, wb_rd=3 wb_result=0x20, both enables 1 -> srca=0x10; with rs1=0 -> srca = held value.
REQ-022 Stall refresh: held rs2=4 value 7, out_ready=0, wb forwards rd=4 result 9 for one cycle then deasserts -> srcb remains 9 after wb drops; in_ready=0 throughout stall.
REQ-023 Immediate shift: cntr=SRA (0111), use_imm=1, imm=0xFFFFFFFB, shamt=2 -> srcb=0xFFFFFFFB, shamt=2; with use_imm=0 and rs2_val=0x23 -> shamt=3.
REQ-024 Illegal op: in_cntr=1011, wb_en=1 -> cntr=0000, illegal_op=1, out_wb_en=0.
REQ-025 Flush/reset: capture and flush same cycle -> out_valid=0 next cycle; rst asserted mid-stall -> out_valid=0, cntr=0, in_ready=1 next cycle.
